// File: rtl/perf_counters_pkg.sv
// Shared definitions for the perf_counters block: FSM state encoding and
// the HALT opcode value.
package perf_counters_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int OPCODE_HALT = 0;

endpackage : perf_counters_pkg

// File: rtl/perf_ctr_cell.sv
// perf_ctr_cell: one counter channel with enable, synchronous clear,
// wrap or saturate arithmetic and a sticky overflow flag.
// With PERF_SNAPSHOT_EN defined, the next-state values are also exported so
// the parent can capture them on the same edge they are written.
module perf_ctr_cell #(
  parameter int W        = 16,
  parameter int SATURATE = 0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_overflow
`ifdef PERF_SNAPSHOT_EN
  ,
  output logic [W-1:0] o_count_d,
  output logic         o_overflow_d
`endif
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q, count_d;
  logic         ovf_q,   ovf_d;

  // Next count: clear wins, otherwise increment with wrap/saturate at MAX.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which is what would otherwise infer a latch.
    count_d = count_q;
    ovf_d   = ovf_q;
    if (i_clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (i_en) begin
      if (count_q == MAX) begin
        ovf_d   = 1'b1;
        count_d = (SATURATE != 0) ? MAX : '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Counter and flag registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its inputs as they were before this edge.
    if (!i_reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_count    = count_q;
  assign o_overflow = ovf_q;
`ifdef PERF_SNAPSHOT_EN
  assign o_count_d    = count_d;
  assign o_overflow_d = ovf_d;
`endif

endmodule : perf_ctr_cell

// File: rtl/perf_counters.sv
// perf_counters: cycle counter (ch0) plus N_CH-1 event counters gated by an
// IDLE/RUN/HALTED measurement FSM, with a registered channel readout.
// Optional feature macro: PERF_SNAPSHOT_EN -- captures all counters and flags
// on the RUN -> HALTED edge and serves reads from that bank while HALTED.
module perf_counters
  import perf_counters_pkg::*;
#(
  parameter int CONTADOR_LENGTH = 16,
  parameter int OPCODE_LENGTH   = 5,
  parameter int N_CH            = 4,
  parameter int SATURATE        = 0
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  logic [OPCODE_LENGTH-1:0]   i_opcode,
  input  logic [N_CH-2:0]            i_event,
  input  logic [$clog2(N_CH)-1:0]    i_sel,
  output logic [CONTADOR_LENGTH-1:0] o_value,
  output logic [N_CH-1:0]            o_overflow,
  output logic [1:0]                 o_state
);

  state_e state_q, state_d;
  logic   start_ok, halt_dec, zero_ctrs, count_en;

  logic [CONTADOR_LENGTH-1:0] cnt    [N_CH];
  logic [CONTADOR_LENGTH-1:0] rd_cnt [N_CH];
  logic [N_CH-1:0]            ovf, rd_ovf, ch_inc;
  logic [CONTADOR_LENGTH-1:0] value_q, value_d;

  // Channel 0 counts every RUN cycle; channel k counts on event bit k-1.
  assign ch_inc = {i_event, 1'b1};

  // Next state and counter controls; clear > start > HALT decode.
  always_comb begin
    state_d   = state_q;
    start_ok  = i_start && (state_q != ST_RUN);
    halt_dec  = (state_q == ST_RUN) && i_valid &&
                (i_opcode == OPCODE_LENGTH'(OPCODE_HALT));
    if (i_clear)       state_d = ST_IDLE;
    else if (start_ok) state_d = ST_RUN;
    else if (halt_dec) state_d = ST_HALTED;
    zero_ctrs = i_clear || start_ok;
    count_en  = (state_q == ST_RUN) && !i_clear;
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CONTADOR_LENGTH-1:0] cnt_nxt [N_CH];
  logic [CONTADOR_LENGTH-1:0] snap_q  [N_CH];
  logic [CONTADOR_LENGTH-1:0] snap_d  [N_CH];
  logic [N_CH-1:0]            ovf_nxt, snap_ovf_q, snap_ovf_d;
  logic                       capture;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    perf_ctr_cell #(
      .W        (CONTADOR_LENGTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_clear      (zero_ctrs),
      .i_en         (count_en && ch_inc[k]),
      .o_count      (cnt[k]),
      .o_overflow   (ovf[k])
`ifdef PERF_SNAPSHOT_EN
      ,
      .o_count_d    (cnt_nxt[k]),
      .o_overflow_d (ovf_nxt[k])
`endif
    );
  end

`ifdef PERF_SNAPSHOT_EN
  // Load the bank with the post-edge counter values when HALT is taken.
  always_comb begin
    capture    = (state_q == ST_RUN) && (state_d == ST_HALTED);
    snap_d     = snap_q;
    snap_ovf_d = snap_ovf_q;
    if (i_clear) begin
      for (int k = 0; k < N_CH; k++) snap_d[k] = '0;
      snap_ovf_d = '0;
    end else if (capture) begin
      snap_d     = cnt_nxt;
      snap_ovf_d = ovf_nxt;
    end
  end

  // Snapshot bank registers.
  always_ff @(posedge i_clock) begin
    // NOTE: this small register bank is reset explicitly because its contents
    // are architecturally visible; large RAM-style storage is normally left
    // unreset.
    if (!i_reset) begin
      for (int k = 0; k < N_CH; k++) snap_q[k] <= '0;
      snap_ovf_q <= '0;
    end else begin
      snap_q     <= snap_d;
      snap_ovf_q <= snap_ovf_d;
    end
  end

  // While HALTED, reads are served from the snapshot bank.
  always_comb begin
    for (int k = 0; k < N_CH; k++)
      rd_cnt[k] = (state_q == ST_HALTED) ? snap_q[k] : cnt[k];
    rd_ovf = (state_q == ST_HALTED) ? snap_ovf_q : ovf;
  end
`else
  // Reads always come from the live counters.
  always_comb begin
    for (int k = 0; k < N_CH; k++) rd_cnt[k] = cnt[k];
    rd_ovf = ovf;
  end
`endif

  // Readout mux; a select beyond the last channel reads zero.
  always_comb begin
    value_d = '0;
    for (int k = 0; k < N_CH; k++)
      if (int'(i_sel) == k) value_d = rd_cnt[k];
  end

  // One-cycle registered readout.
  always_ff @(posedge i_clock) begin
    if (!i_reset) value_q <= '0;
    else          value_q <= value_d;
  end

  assign o_value    = value_q;
  assign o_overflow = rd_ovf;
  assign o_state    = state_q;

endmodule : perf_counters
